// File: rtl/axi4_full_to_stream.sv
// MM2S mover: one AXI4 INCR read burst per start pulse, replayed as an AXI4-Stream
// master through a small registered FIFO, with TLAST generated from the beat counter.
module axi4_full_to_stream #(
   parameter int unsigned C_AXI_DATA_WIDTH     = 32,
   parameter int unsigned C_M_AXI_BURST_LEN    = 256,
   parameter int unsigned C_M_AXI_ID_WIDTH     = 1,
   parameter int unsigned C_M_AXI_ADDR_WIDTH   = 32,
   parameter int unsigned C_M_AXI_ARUSER_WIDTH = 1,
   parameter int unsigned C_FIFO_DEPTH         = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic                              sw_reset,
   output logic                              sw_reset_ok,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     read_address,
   input  logic                              read_start,
   output logic                              output_idle,
   output logic                              output_error,
   output logic [C_AXI_DATA_WIDTH-1:0]       debug_data_sum,
   output logic                              M_AXIS_TVALID,
   input  logic                              M_AXIS_TREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]       M_AXIS_TDATA,
   output logic [C_AXI_DATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
   output logic                              M_AXIS_TLAST,
   output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [7:0]                        M_AXI_ARLEN,
   output logic [2:0]                        M_AXI_ARSIZE,
   output logic [1:0]                        M_AXI_ARBURST,
   output logic                              M_AXI_ARLOCK,
   output logic [3:0]                        M_AXI_ARCACHE,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic [3:0]                        M_AXI_ARQOS,
   output logic [C_M_AXI_ARUSER_WIDTH-1:0]   M_AXI_ARUSER,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
   input  logic [C_AXI_DATA_WIDTH-1:0]       M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RLAST,
   input  logic                              M_AXI_RUSER,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = $clog2(C_M_AXI_BURST_LEN);
   localparam int unsigned PTR_W  = $clog2(C_FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

   state_t                          r_state;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
   logic [CNT_W-1:0]                r_beat;
   logic                            r_error;
   logic [C_AXI_DATA_WIDTH-1:0]     r_sum;
   logic                            r_sw_ok;
   logic [PTR_W-1:0]                r_wr_ptr;
   logic [PTR_W-1:0]                r_rd_ptr;
   logic [LVL_W-1:0]                r_level;
   logic [C_AXI_DATA_WIDTH-1:0]     r_mem_data [C_FIFO_DEPTH];
   logic                            r_mem_last [C_FIFO_DEPTH];

   logic w_full, w_empty, w_rready, w_rbeat, w_final, w_push, w_tvalid, w_pop, w_start;
   logic w_unused_ok;

   assign w_full   = (r_level == LVL_W'(C_FIFO_DEPTH));
   assign w_empty  = (r_level == '0);
   // Under sw_reset the R channel is drained unconditionally and beats are dropped.
   assign w_rready = (r_state == S_DATA) && (sw_reset || !w_full);
   assign w_rbeat  = w_rready && M_AXI_RVALID;
   assign w_final  = (r_beat == CNT_W'(C_M_AXI_BURST_LEN - 1));
   assign w_push   = w_rbeat && !sw_reset;
   assign w_tvalid = !w_empty && !sw_reset;
   assign w_pop    = w_tvalid && M_AXIS_TREADY;
   assign w_start  = (r_state == S_IDLE) && read_start && !sw_reset;

   // Control FSM, address latch, beat counter and sticky error.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state  <= S_IDLE;
         r_araddr <= '0;
         r_beat   <= '0;
         r_error  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_araddr <= read_address;
               r_beat   <= '0;
               r_error  <= 1'b0;
               r_state  <= S_ADDR;
            end
            S_ADDR: if (M_AXI_ARREADY) r_state <= S_DATA;
            S_DATA: if (w_rbeat) begin
               r_beat <= r_beat + CNT_W'(1);
               if ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != w_final)) r_error <= 1'b1;
               if (w_final) r_state <= S_DRAIN;
            end
            S_DRAIN: if (sw_reset || w_empty || ((r_level == LVL_W'(1)) && w_pop))
               r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // FIFO pointers and fill level; sw_reset discards all buffered beats.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (sw_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      end
   end

   always_ff @(posedge ACLK) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= M_AXI_RDATA;
         r_mem_last[r_wr_ptr] <= w_final;
      end
   end

   // Debug checksum and flush-complete flag.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_sum   <= '0;
         r_sw_ok <= 1'b0;
      end else begin
         if (w_pop) r_sum <= r_sum + r_mem_data[r_rd_ptr];
         r_sw_ok <= sw_reset && (r_state == S_IDLE) && w_empty;
      end
   end

   assign w_unused_ok = ^{M_AXI_RID, M_AXI_RUSER};

   assign sw_reset_ok    = r_sw_ok;
   assign output_idle    = (r_state == S_IDLE);
   assign output_error   = r_error;
   assign debug_data_sum = r_sum;
   assign M_AXIS_TVALID  = w_tvalid;
   assign M_AXIS_TDATA   = r_mem_data[r_rd_ptr];
   assign M_AXIS_TLAST   = w_tvalid && r_mem_last[r_rd_ptr];
   assign M_AXIS_TSTRB   = {STRB_W{1'b1}};
   assign M_AXI_ARID     = '0;
   assign M_AXI_ARADDR   = r_araddr;
   assign M_AXI_ARLEN    = 8'(C_M_AXI_BURST_LEN - 1);
   assign M_AXI_ARSIZE   = 3'($clog2(STRB_W));
   assign M_AXI_ARBURST  = 2'b01;
   assign M_AXI_ARLOCK   = 1'b0;
   assign M_AXI_ARCACHE  = 4'b0011;
   assign M_AXI_ARPROT   = 3'b000;
   assign M_AXI_ARQOS    = 4'b0000;
   assign M_AXI_ARUSER   = '0;
   assign M_AXI_ARVALID  = (r_state == S_ADDR);
   assign M_AXI_RREADY   = w_rready;

endmodule
